// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB PWM fader.
//   DUTY_W       : width of one colour channel duty value
//   rgb_t        : packed {r, g, b} duty triple, r in the MSBs
//   fade_state_t : command FSM states
package rgb_pwm_pkg;

  localparam int DUTY_W = 8;

  typedef struct packed {
    logic [DUTY_W-1:0] r;
    logic [DUTY_W-1:0] g;
    logic [DUTY_W-1:0] b;
  } rgb_t;

  typedef enum logic {
    IDLE,
    FADE
  } fade_state_t;

endpackage

// File: rtl/rgb_pwm_fader_if.sv
// Colour command handshake between a command source and the fader.
//   cmd_valid : source has a command
//   cmd_ready : fader can accept a command
//   cmd_rgb   : target duty {R, G, B}
//   cmd_fade  : 1 = ramp to target, 0 = apply immediately
interface rgb_pwm_fader_if;

  logic               cmd_valid;
  logic               cmd_ready;
  rgb_pwm_pkg::rgb_t  cmd_rgb;
  logic               cmd_fade;

  modport master (output cmd_valid, output cmd_rgb, output cmd_fade, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_rgb, input  cmd_fade, output cmd_ready);

endinterface

// File: rtl/pwm_channel.sv
// One PWM colour channel: working duty (cur), period-latched active duty
// (act), fade target (tgt), fade stepping and the registered PWM output.
//   clk, rst      : clock, synchronous active-high reset
//   pwm_cnt_i     : shared PWM counter
//   wrap_i        : last clock of a PWM period
//   load_cur_i    : immediate command, cur <= duty_i
//   load_tgt_i    : fade command, tgt <= duty_i
//   step_en_i     : fade in progress, step cur toward tgt on wrap
//   duty_i        : commanded duty for this channel
//   pwm_o         : PWM output bit
//   at_target_o   : cur will equal tgt after this clock edge
//   cur_o         : current working duty
module pwm_channel
  import rgb_pwm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] pwm_cnt_i,
  input  logic              wrap_i,
  input  logic              load_cur_i,
  input  logic              load_tgt_i,
  input  logic              step_en_i,
  input  logic [DUTY_W-1:0] duty_i,
  output logic              pwm_o,
  output logic              at_target_o,
  output logic [DUTY_W-1:0] cur_o
);

  logic [DUTY_W-1:0] cur_q, cur_d;
  logic [DUTY_W-1:0] act_q;
  logic [DUTY_W-1:0] tgt_q;
  logic              pwm_q;

  // NOTE: cur_d gets its hold value first so every path assigns it and no latch is inferred.
  always_comb begin
    cur_d = cur_q;
    if (load_cur_i) begin
      cur_d = duty_i;
    end else if (step_en_i && wrap_i) begin
      if (cur_q < tgt_q) begin
        cur_d = cur_q + DUTY_W'(1);
      end else if (cur_q > tgt_q) begin
        cur_d = cur_q - DUTY_W'(1);
      end
    end
  end

  // Looks at the post-step value so the FSM can leave FADE on the final wrap.
  assign at_target_o = (cur_d == tgt_q);
  assign cur_o       = cur_q;
  assign pwm_o       = pwm_q;

  // NOTE: non-blocking assignments, so act_q captures the pre-edge cur_q on wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= '0;
      act_q <= '0;
      tgt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cur_q <= cur_d;
      if (load_tgt_i) tgt_q <= duty_i;
      if (wrap_i)     act_q <= cur_q;
      // Duty 255 is high for counts 0..254 only; duty 0 never goes high.
      pwm_q <= (pwm_cnt_i < act_q);
    end
  end

endmodule

// File: rtl/rgb_pwm_fader.sv
// Three-channel 8-bit PWM generator with a linear fade engine.
//   PRESCALE  : clocks per PWM counter step (>= 1); period = 256*PRESCALE
//   clk, rst  : clock, synchronous active-high reset
//   cmd       : colour command handshake (slave side)
//   busy_o    : fade in progress
//   pwm_out_o : [0]=R, [1]=G, [2]=B, to the LED pad driver din
module rgb_pwm_fader
  import rgb_pwm_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic           clk,
  input  logic           rst,
  rgb_pwm_fader_if.slave cmd,
  output logic           busy_o,
  output logic [2:0]     pwm_out_o
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]  pre_q;
  logic [DUTY_W-1:0] pwm_cnt_q;
  fade_state_t       state_q;

  logic        tick, wrap, fading, accept, load_cur, load_tgt;
  rgb_t        cmd_duty, cur_duty;
  logic [2:0]  at_target;
  logic [DUTY_W-1:0] cur_r, cur_g, cur_b;

  assign tick   = (pre_q == PRE_W'(PRESCALE - 1));
  assign wrap   = tick && (pwm_cnt_q == '1);
  assign fading = (state_q == FADE);

  assign cmd.cmd_ready = !fading;
  assign busy_o        = fading;

  assign cmd_duty = cmd.cmd_rgb;
  assign cur_duty = '{r: cur_r, g: cur_g, b: cur_b};
  assign accept   = cmd.cmd_valid && !fading;
  assign load_cur = accept && !cmd.cmd_fade;
  // A fade to the colour already held is a no-op and never enters FADE.
  assign load_tgt = accept && cmd.cmd_fade && (cmd_duty != cur_duty);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      pwm_cnt_q <= '0;
      state_q   <= IDLE;
    end else begin
      pre_q <= tick ? '0 : pre_q + PRE_W'(1);
      if (tick) pwm_cnt_q <= pwm_cnt_q + DUTY_W'(1);
      case (state_q)
        IDLE:    if (load_tgt) state_q <= FADE;
        FADE:    if (wrap && (&at_target)) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  pwm_channel u_ch_r (
    .clk(clk), .rst(rst), .pwm_cnt_i(pwm_cnt_q), .wrap_i(wrap),
    .load_cur_i(load_cur), .load_tgt_i(load_tgt), .step_en_i(fading),
    .duty_i(cmd_duty.r), .pwm_o(pwm_out_o[0]), .at_target_o(at_target[0]), .cur_o(cur_r)
  );

  pwm_channel u_ch_g (
    .clk(clk), .rst(rst), .pwm_cnt_i(pwm_cnt_q), .wrap_i(wrap),
    .load_cur_i(load_cur), .load_tgt_i(load_tgt), .step_en_i(fading),
    .duty_i(cmd_duty.g), .pwm_o(pwm_out_o[1]), .at_target_o(at_target[1]), .cur_o(cur_g)
  );

  pwm_channel u_ch_b (
    .clk(clk), .rst(rst), .pwm_cnt_i(pwm_cnt_q), .wrap_i(wrap),
    .load_cur_i(load_cur), .load_tgt_i(load_tgt), .step_en_i(fading),
    .duty_i(cmd_duty.b), .pwm_o(pwm_out_o[2]), .at_target_o(at_target[2]), .cur_o(cur_b)
  );

endmodule

// File: doc/rgb_pwm_fader.md
# rgb_pwm_fader

Three-channel 8-bit PWM generator with a linear fade engine, sitting directly upstream of the RGB LED pad driver: its `pwm_out[2:0]` feeds the driver's `din[2:0]`. It accepts colour commands over a valid/ready handshake and either applies them immediately or ramps each channel toward the target one LSB per PWM period. Duty changes are double-buffered so a period never contains a partial update.

## Interface
- `PRESCALE`, default 4: clocks per PWM counter step; legal range ≥1. PWM period = 256·PRESCALE clocks.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_rgb`  in  24  target duty {R[23:16], G[15:8], B[7:0]}.
- `cmd_fade`  in  1  1 = ramp to target, 0 = apply immediately.
- `busy`  out  1  fade in progress.
- `pwm_out`  out  3  [0]=R, [1]=G, [2]=B; to LED pad driver `din`.

## Operation
- Prescaler `pre` counts 0..PRESCALE-1; `tick` = (pre == PRESCALE-1).
- 8-bit `pwm_cnt` increments on `tick`, wraps 255→0. `wrap` = tick && pwm_cnt == 255.
- Per channel: `cur` (working duty), `act` (active duty), `tgt` (fade target), all 8-bit.
- On `wrap`: `act <= cur`, using the pre-edge value of `cur`.
- `pwm_out[c]` registered: `pwm_cnt < act[c]`. Duty 0 keeps the output always low. Duty 255 keeps it high for 255 of 256 steps.
- FSM states: IDLE, FADE.
  - IDLE: `cmd_ready=1`, `busy=0`. On `cmd_valid && cmd_ready`:
    - `cmd_fade=0`: `cur <= cmd_rgb`, stay in IDLE.
    - `cmd_fade=1` and `cmd_rgb != cur`: `tgt <= cmd_rgb`, go to FADE.
    - `cmd_fade=1` and `cmd_rgb == cur`: treat as a no-op and stay in IDLE.
  - FADE: `cmd_ready=0`, `busy=1`. On each `wrap`, every channel with `cur != tgt` steps `cur` by ±1 toward `tgt`. If all channels equal their targets after the step, go to IDLE.
- `cur` steps only on `wrap`, never mid-period. The unsigned compare picks the step direction; `cur` cannot overshoot.
- Reset values: pre=0, pwm_cnt=0, cur/act/tgt=0, pwm_out=000, state=IDLE, busy=0. `cmd_ready`=1 from the first cycle after `rst` deasserts.

## Timing
- `cmd_ready` and `busy` are decoded combinationally from the state register.
- `pwm_out` is registered, so `pwm_out` at cycle t+1 reflects `pwm_cnt`/`act` at cycle t.
- Immediate command: `cur` updates at the accepting edge. It becomes active at the next `wrap` and is visible on `pwm_out` one cycle later.
- Accept coinciding with `wrap`: `act` loads the old `cur`, so the new value takes effect one full period later.
- Fade duration: max over channels of |tgt−cur| periods. `busy` falls in the cycle after the final `wrap`.
- `cmd_valid` while in FADE is not accepted. The command must be held; it is accepted on the first cycle back in IDLE.
- Reset mid-fade: the fade is abandoned and every register takes its reset value at the edge. `pwm_out=000` in the cycle following that edge.

## Structure
- Package `rgb_pwm_pkg` holds:
  - `DUTY_W = 8`;
  - `typedef struct packed {logic [7:0] r, g, b;} rgb_t`;
  - `typedef enum logic {IDLE, FADE} fade_state_t`.
- Sub-module `pwm_channel`, instantiated ×3:
  - holds `cur`/`act`/`tgt`, the step logic and the output register;
  - inputs: `pwm_cnt`, `wrap`, load strobes;
  - outputs: `pwm_out` bit and `at_target`.
- The top level holds the prescaler, `pwm_cnt` and the FSM.

## Test plan
- Reset with PRESCALE=1 → `pwm_out=000`, `busy=0`, `cmd_ready=1` on the first cycle after reset; `pwm_out` stays 000 for 512 cycles.
- Immediate command 0x80_00_FF, PRESCALE=1 → from the second period: R high 128 of each 256 cycles, G always low, B high 255 of 256.
- Fade from 0 to 0x04_00_02, PRESCALE=1:
  - `busy=1` for exactly 4 periods (1024 cycles);
  - R duty per period 1, 2, 3, 4;
  - B duty per period 1, 2, 2, 2;
  - `cmd_ready=0` throughout.
- Fade down from 0x03_03_03 to 0 → duties 2, 1, 0; `busy` lasts 3 periods; `pwm_out` is all-low afterwards.
- `cmd_valid` held during a fade with an immediate 0xFF_FF_FF → not accepted until IDLE, accepted on the first ready cycle, full duty one period later.
- Reset asserted mid-fade, then PRESCALE=3 with immediate duty 0x40 → outputs are zero the cycle after reset; then period is 768 clocks with R high for 192.
